// File: rtl/spc_playlist_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | spc_ctrl_pkg: shared types and song-target arithmetic for the playlist ctl |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package spc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_LOAD_REQ,
        ST_LOAD_WAIT,
        ST_PLAY,
        ST_FAIL
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE,
        PEND_NEXT,
        PEND_PREV
    } pend_t;

    // An empty playlist maps every request to song 0 and lets the loader fail.
    function automatic logic [15:0] target_song(input pend_t dir, input logic [15:0] cur,
                                                 input logic [15:0] total);
        logic [15:0] t;
        t = 16'd0;
        if (total == 16'd0)
            t = 16'd0;
        else if (dir == PEND_PREV)
            t = (cur == 16'd0) ? total - 16'd1 : cur - 16'd1;
        else
            t = (cur + 16'd1 == total) ? 16'd0 : cur + 16'd1;
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// +----------------------------------------------------------------------------+
// | btn_debounce: 2-FF synchroniser, stability counter, rising-edge pulse      |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 495000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn,
    output logic rise
);

    logic        meta;
    logic        sync;
    logic        stable;
    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
            rise   <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            rise <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt >= 32'(DEBOUNCE_CYCLES - 1)) begin
                // Input has differed from the accepted level long enough.
                cnt    <= '0;
                stable <= sync;
                rise   <= sync;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/spc_playlist_ctrl.sv
// +----------------------------------------------------------------------------+
// | spc_playlist_ctrl: drives the SPC loader and APU reset, steps the playlist |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module spc_playlist_ctrl
    import spc_ctrl_pkg::*;
#(
    parameter int FREQ            = 24_750_000,
    parameter int DEBOUNCE_CYCLES = FREQ / 50,
    parameter int TICK_CYCLES     = FREQ,
    parameter int PLAY_SECONDS    = 180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        btn_next,
    input  logic        btn_prev,
    output logic        ld_start,
    output logic [15:0] ld_num,
    input  logic [15:0] ld_total,
    input  logic        ld_done,
    input  logic        ld_fail,
    output logic        apu_reset,
    output logic        playing,
    output logic [15:0] cur_song,
    output logic        err,
    output logic [7:0]  sec_cnt
);

    state_t      state;
    state_t      state_nxt;
    pend_t       pending;
    pend_t       req;
    pend_t       load_dir;
    logic        load_go;
    logic        auto_adv;
    logic        next_ev;
    logic        prev_ev;
    logic [31:0] tick_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btn_next),
        .rise   (next_ev)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk    (clk),
        .resetn (resetn),
        .btn    (btn_prev),
        .rise   (prev_ev)
    );

    assign ld_start  = (state == ST_LOAD_REQ);
    assign apu_reset = (state != ST_PLAY);
    assign playing   = (state == ST_PLAY);
    assign err       = (state == ST_FAIL);

    always_comb begin
        req       = pending;
        state_nxt = state;
        load_go   = 1'b0;
        load_dir  = PEND_NEXT;
        auto_adv  = (PLAY_SECONDS != 0) && ({24'd0, sec_cnt} == 32'(PLAY_SECONDS));
        // A fresh event this cycle beats both the held request and auto-advance.
        if (next_ev)
            req = PEND_NEXT;
        else if (prev_ev)
            req = PEND_PREV;
        case (state)
            ST_BOOT:      state_nxt = ST_LOAD_REQ;
            ST_LOAD_REQ:  state_nxt = ST_LOAD_WAIT;
            ST_LOAD_WAIT: begin
                if (ld_fail)
                    state_nxt = ST_FAIL;
                else if (ld_done)
                    state_nxt = ST_PLAY;
            end
            ST_PLAY: begin
                if (req != PEND_NONE) begin
                    state_nxt = ST_LOAD_REQ;
                    load_go   = 1'b1;
                    load_dir  = req;
                end else if (auto_adv) begin
                    state_nxt = ST_LOAD_REQ;
                    load_go   = 1'b1;
                end
            end
            ST_FAIL:      state_nxt = ST_FAIL;
            default:      state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_BOOT;
            pending  <= PEND_NONE;
            ld_num   <= '0;
            cur_song <= '0;
            sec_cnt  <= '0;
            tick_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (state == ST_FAIL || load_go)
                pending <= PEND_NONE;
            else if (next_ev)
                pending <= PEND_NEXT;
            else if (prev_ev)
                pending <= PEND_PREV;

            if (state == ST_BOOT)
                ld_num <= '0;
            else if (load_go)
                ld_num <= target_song(load_dir, cur_song, ld_total);

            if (state == ST_LOAD_WAIT && !ld_fail && ld_done)
                cur_song <= ld_num;

            if (state_nxt == ST_LOAD_REQ || (state == ST_LOAD_WAIT && ld_done)) begin
                tick_cnt <= '0;
                sec_cnt  <= '0;
            end else if (state == ST_PLAY) begin
                if (tick_cnt == 32'(TICK_CYCLES - 1)) begin
                    tick_cnt <= '0;
                    if (sec_cnt != 8'hFF)
                        sec_cnt <= sec_cnt + 8'd1;
                end else begin
                    tick_cnt <= tick_cnt + 32'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spc_playlist_ctrl.sv
// +----------------------------------------------------------------------------+
// | tb_spc_playlist_ctrl: scoreboard bench, manual-step and auto-advance units |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_spc_playlist_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        btn_next;
    logic        btn_prev;
    logic        ld_start;
    logic [15:0] ld_num;
    logic [15:0] ld_total = 16'd5;
    logic        ld_done;
    logic        ld_fail;
    logic        apu_reset;
    logic        playing;
    logic [15:0] cur_song;
    logic        err;
    logic [7:0]  sec_cnt;

    logic        a_ld_start;
    logic [15:0] a_ld_num;
    logic        a_ld_done;
    logic        a_apu_reset;
    logic        a_playing;
    logic [15:0] a_cur_song;
    logic        a_err;
    logic [7:0]  a_sec_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];
    int          loads = 0;
    int          lat = 100;
    bit          fail_mode = 1'b0;

    always #5 clk = ~clk;

    spc_playlist_ctrl #(.DEBOUNCE_CYCLES(8), .TICK_CYCLES(10), .PLAY_SECONDS(0)) dut (
        .clk(clk), .resetn(resetn), .btn_next(btn_next), .btn_prev(btn_prev),
        .ld_start(ld_start), .ld_num(ld_num), .ld_total(ld_total), .ld_done(ld_done),
        .ld_fail(ld_fail), .apu_reset(apu_reset), .playing(playing), .cur_song(cur_song),
        .err(err), .sec_cnt(sec_cnt)
    );

    spc_playlist_ctrl #(.DEBOUNCE_CYCLES(8), .TICK_CYCLES(10), .PLAY_SECONDS(2)) dut_auto (
        .clk(clk), .resetn(resetn), .btn_next(1'b0), .btn_prev(1'b0),
        .ld_start(a_ld_start), .ld_num(a_ld_num), .ld_total(ld_total), .ld_done(a_ld_done),
        .ld_fail(1'b0), .apu_reset(a_apu_reset), .playing(a_playing), .cur_song(a_cur_song),
        .err(a_err), .sec_cnt(a_sec_cnt)
    );

    // Loader models: done (or fail) rises lat cycles after the start pulse.
    int ld_cnt;
    bit busy;
    always @(posedge clk) begin
        if (!resetn) begin
            ld_done <= 1'b0; ld_fail <= 1'b0; busy <= 1'b0; ld_cnt <= 0;
        end else if (ld_start) begin
            ld_done <= 1'b0; busy <= 1'b1; ld_cnt <= lat - 1;
        end else if (busy) begin
            if (ld_cnt == 0) begin
                busy <= 1'b0;
                if (fail_mode) ld_fail <= 1'b1;
                else           ld_done <= 1'b1;
            end else begin
                ld_cnt <= ld_cnt - 1;
            end
        end
    end

    int a_cnt;
    bit a_busy;
    always @(posedge clk) begin
        if (!resetn) begin
            a_ld_done <= 1'b0; a_busy <= 1'b0; a_cnt <= 0;
        end else if (a_ld_start) begin
            a_ld_done <= 1'b0; a_busy <= 1'b1; a_cnt <= 4;
        end else if (a_busy) begin
            if (a_cnt == 0) begin a_busy <= 1'b0; a_ld_done <= 1'b1; end
            else a_cnt <= a_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Main scoreboard monitor: every load request pops one expected song number.
    always @(negedge clk) begin
        if (resetn && ld_start) begin
            loads++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ld_start: got ld_num %0d expected no load", ld_num);
            end else begin
                check("ld_num", {16'd0, ld_num}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // Auto-advance monitor: songs step 0,1,2,3,4,0,... with a fixed play time.
    int a_exp = 0;
    int a_play = 0;
    int a_loads = 0;
    always @(negedge clk) begin
        if (resetn) begin
            if (a_playing) a_play++;
            if (a_ld_start) begin
                check("auto_ld_num", {16'd0, a_ld_num}, 32'(a_exp));
                if (a_loads > 0)
                    check("auto_play_cycles_20_21", {31'd0, (a_play == 20 || a_play == 21)}, 32'd1);
                a_exp = (a_exp + 1) % 5;
                a_play = 0;
                a_loads++;
            end
        end
    end

    task automatic press(input bit nxt, input int hold);
        if (nxt) btn_next = 1'b1; else btn_prev = 1'b1;
        repeat (hold) @(negedge clk);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        repeat (hold) @(negedge clk);
    endtask

    task automatic wait_loads(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (loads < n && c < budget) begin @(negedge clk); c++; end
        check(name, 32'(loads), 32'(n));
    endtask

    task automatic wait_play(input int budget, input string name);
        int c;
        c = 0;
        while (!playing && c < budget) begin @(negedge clk); c++; end
        check(name, {31'd0, playing}, 32'd1);
    endtask

    initial begin
        int c;
        resetn = 1'b0; btn_next = 1'b0; btn_prev = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ld_start", {31'd0, ld_start}, 32'd0);
        check("rst_ld_num", {16'd0, ld_num}, 32'd0);
        check("rst_apu_reset", {31'd0, apu_reset}, 32'd1);
        check("rst_playing", {31'd0, playing}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_cur_song", {16'd0, cur_song}, 32'd0);
        check("rst_sec_cnt", {24'd0, sec_cnt}, 32'd0);

        exp_q.push_back(16'd0);
        resetn = 1'b1;
        c = 0;
        while (!ld_done && c < 300) begin @(negedge clk); c++; end
        check("boot_done_seen", {31'd0, ld_done}, 32'd1);
        check("apu_reset_at_done", {31'd0, apu_reset}, 32'd1);
        @(negedge clk);
        check("apu_released", {31'd0, apu_reset}, 32'd0);
        check("boot_playing", {31'd0, playing}, 32'd1);
        check("boot_cur_song", {16'd0, cur_song}, 32'd0);
        check("boot_loads", 32'(loads), 32'd1);

        lat = 20;
        exp_q.push_back(16'd4);
        press(1'b0, 14);
        wait_loads(2, 100, "prev_load");
        wait_play(100, "prev_play");
        check("prev_wrap_cur", {16'd0, cur_song}, 32'd4);

        exp_q.push_back(16'd0);
        press(1'b1, 14);
        wait_loads(3, 100, "next_load");
        wait_play(100, "next_play");
        check("next_wrap_cur", {16'd0, cur_song}, 32'd0);

        lat = 100;
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd2);
        press(1'b1, 14);
        press(1'b0, 14);
        press(1'b1, 14);
        lat = 20;
        wait_loads(4, 200, "held_first_load");
        wait_play(200, "held_first_play");
        check("held_first_cur", {16'd0, cur_song}, 32'd1);
        wait_loads(5, 50, "held_reload");
        wait_play(100, "held_reload_play");
        repeat (50) @(negedge clk);
        check("held_single_reload", 32'(loads), 32'd5);
        check("held_reload_cur", {16'd0, cur_song}, 32'd2);

        exp_q.push_back(16'd3);
        for (int i = 0; i < 10; i++) begin
            btn_next = ~btn_next;
            repeat (3) @(negedge clk);
        end
        btn_next = 1'b0;
        repeat (15) @(negedge clk);
        check("bounce_no_event", 32'(loads), 32'd5);
        btn_next = 1'b1;
        repeat (20) @(negedge clk);
        btn_next = 1'b0;
        wait_loads(6, 100, "bounce_load");
        wait_play(100, "bounce_play");
        check("bounce_sec_start", {24'd0, sec_cnt}, 32'd0);

        repeat (2600) @(negedge clk);
        check("no_auto_loads", 32'(loads), 32'd6);
        check("sec_saturate", {24'd0, sec_cnt}, 32'd255);
        check("bounce_cur", {16'd0, cur_song}, 32'd3);

        fail_mode = 1'b1;
        exp_q.push_back(16'd4);
        press(1'b1, 14);
        wait_loads(7, 100, "fail_load");
        c = 0;
        while (!err && c < 100) begin @(negedge clk); c++; end
        check("fail_err", {31'd0, err}, 32'd1);
        check("fail_apu_reset", {31'd0, apu_reset}, 32'd1);
        check("fail_playing", {31'd0, playing}, 32'd0);
        press(1'b1, 14);
        press(1'b0, 14);
        repeat (30) @(negedge clk);
        check("fail_no_load", 32'(loads), 32'd7);
        check("fail_err_sticky", {31'd0, err}, 32'd1);
        check("fail_cur_kept", {16'd0, cur_song}, 32'd3);

        check("auto_loads_min", {31'd0, (a_loads >= 10)}, 32'd1);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (20000) @(negedge clk);
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spc_playlist_ctrl.md
# spc_playlist_ctrl

Sequencer that drives the SD SPC loader and decides which song the APU plays. It issues load requests (song number and start pulse), holds the APU in reset while a song image streams in, and releases it on completion. It steps through the playlist on debounced next/prev buttons or a play-time auto-advance timer, wrapping at the song count reported by the loader. It sits between the board buttons, the loader and the APU/SPC700 reset.

## Interface
- FREQ, 24_750_000, clk frequency in Hz (informational; defaults below derive from it)
- DEBOUNCE_CYCLES, FREQ/50 (20 ms), cycles an input must be stable before it is accepted
- TICK_CYCLES, FREQ, cycles per play-time second
- PLAY_SECONDS, 180, auto-advance after this many seconds of play; 0 disables auto-advance
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- btn_next  in  1  raw button, active-high, asynchronous; 2-FF synchronised inside
- btn_prev  in  1  raw button, active-high, asynchronous; 2-FF synchronised inside
- ld_start  out  1  one-cycle load request to the loader
- ld_num  out  16  song number to load; stable from the ld_start cycle until done/fail
- ld_total  in  16  song count from the loader; valid after the first successful load
- ld_done  in  1  loader completion (level)
- ld_fail  in  1  loader failure (level, sticky in the loader until reset)
- apu_reset  out  1  high holds the APU in reset
- playing  out  1  high while in PLAY
- cur_song  out  16  last successfully loaded song
- err  out  1  sticky load failure
- sec_cnt  out  8  seconds played in the current song, saturating at 255

## Operation
- States: BOOT, LOAD_REQ, LOAD_WAIT, PLAY, FAIL.
- Reset values: ld_start=0, ld_num=0, cur_song=0, apu_reset=1, playing=0, err=0, sec_cnt=0, pending=none, state=BOOT.
- BOOT: go to LOAD_REQ unconditionally (loads song 0 after every reset).
- LOAD_REQ: ld_start=1 for exactly one cycle, apu_reset=1, next state LOAD_WAIT.
- LOAD_WAIT: ld_done/ld_fail are ignored in the ld_start cycle itself. On ld_fail: go to FAIL. Otherwise on ld_done: cur_song<=ld_num, sec_cnt<=0, go to PLAY. ld_fail wins if both are high.
- PLAY: apu_reset=0, playing=1.
  - If a request is pending, compute the target and go to LOAD_REQ, then clear pending.
  - Else if PLAY_SECONDS!=0 and sec_cnt reaches PLAY_SECONDS, do a next.
- FAIL: err=1, apu_reset=1. Stays here until reset; buttons are ignored.
- Target arithmetic is 16-bit, relative to cur_song:
  - next = (cur_song+1 == ld_total) ? 0 : cur_song+1
  - prev = (cur_song == 0) ? ld_total-1 : cur_song-1
  - If ld_total==0, next=prev=0; the loader then fails, which is acceptable.
- Button events: a debounced rising edge sets pending to NEXT or PREV.
  - The latest event overwrites pending (one-deep, last wins).
  - next and prev in the same cycle: NEXT wins.
  - Events during LOAD_REQ/LOAD_WAIT are held in pending and applied on the first PLAY cycle.
  - A button event in the same cycle as auto-advance: the button wins.
- Play timer: a tick counter runs only in PLAY and wraps at TICK_CYCLES-1, incrementing sec_cnt. Both are cleared on entry to LOAD_REQ.

## Timing
- Button press to ld_start: DEBOUNCE_CYCLES + 2 (sync) + 1 (edge) + 2 (PLAY→LOAD_REQ) cycles worst case.
- ld_start is high in LOAD_REQ only; ld_num is updated in the same cycle the state enters LOAD_REQ.
- apu_reset rises in the LOAD_REQ cycle and falls the cycle after ld_done is sampled.
- ld_done high in the first LOAD_WAIT-sampled cycle → PLAY on the next edge.
- resetn low mid-load: all state returns to reset values immediately. Song 0 is reloaded; the loader is reset by the same resetn.

## Structure
- Package spc_ctrl_pkg holds the state enum and the pending encoding (NONE/NEXT/PREV).
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES) contains the 2-FF synchroniser, stability counter and rising-edge pulse. It is instantiated twice.

## Test plan
- Reset release, loader model asserts done 100 cycles after start → ld_start pulse with ld_num=0, apu_reset high until the cycle after done, cur_song=0, playing=1.
- ld_total=5, cur_song=4, press next → ld_num=0; from cur_song=0, press prev → ld_num=4.
- Loader asserts ld_fail → err=1, apu_reset=1, later button presses produce no ld_start.
- During LOAD_WAIT press prev then next → single reload with the next target right after done; no second load.
- PLAY_SECONDS=2, TICK_CYCLES=10 → auto ld_start 20 cycles after entering PLAY with ld_num=cur_song+1; PLAY_SECONDS=0 → never.
- Bounce: btn_next toggling every 3 cycles with DEBOUNCE_CYCLES=8, then held high → exactly one next event.
